codificador_trit_param: RTL and testbench

// - Parametrised successor to the fixed 8-address/4-data trit encoder.
// - Serialises N_ADDR tri-state address trits, N_DATA data bits and one sync segment onto cod_o.
// - Drives the RF/OOK modulator. The frame repeats while te is held, with a guaranteed minimum repeat count.
// - Floating address lines are given by an explicit mask, not by 'z', so the block is synthesisable.

---
 rtl/codificador_pkg.sv | 22 ++
 rtl/osc_tick_gen.sv | 31 +++
 rtl/codificador_trit_param.sv | 148 ++++++++++++++
 tb/tb_codificador_trit_param.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/codificador_pkg.sv
// Shared types, segment timing constants and waveform helper for the trit encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package codificador_pkg;

  typedef enum logic [1:0] {TRIT_0, TRIT_1, TRIT_F} trit_t;
  typedef enum logic [1:0] {IDLE, BITS, SYNC} state_t;

  localparam int BIT_TICKS  = 32;
  localparam int SYNC_TICKS = 128;
  localparam int SHORT      = 4;
  localparam int LONG       = 12;

  // Each bit is two 16-tick halves, each "high for N ticks, then low".
  // '1' is long-long, '0' short-short, 'F' short-long.
  function automatic logic [3:0] half_high_ticks(input trit_t t, input logic second_half);
    if (t == TRIT_1) return 4'(LONG);
    if (t == TRIT_F && second_half) return 4'(LONG);
    return 4'(SHORT);
  endfunction

endpackage

// File: rtl/osc_tick_gen.sv
// Free-running clock divider producing the osc tick strobe.
// Latency: tick is high for one clk every CLK_DIV clk, first after CLK_DIV clk out of reset.
// Backpressure: none; runs continuously.
// Ports: clk (system clock), reset (async, active-high), tick (one-clk strobe).
module osc_tick_gen #(
  parameter int CLK_DIV = 99
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(CLK_DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/codificador_trit_param.sv
// Parametrised trit encoder: serialises address trits, data bits (+ optional parity) and sync onto cod_o.
// Latency: word starts on the first osc tick with te=1; each word is fixed length in ticks.
// Backpressure: none; te is level-sensitive and only sampled in IDLE and at word boundaries.
// Ports: clk, reset (async, active-high), A/A_float/D (word content), te (transmit enable),
//        cod_o (serial waveform), sync (pulse at sync start), busy, word_done (pulse at word end).
// Optional feature: define CODIFICADOR_PARITY_EN to append an even-parity bit (^D) after D.
module codificador_trit_param
  import codificador_pkg::*;
#(
  parameter int N_ADDR     = 8,
  parameter int N_DATA     = 4,
  parameter int CLK_DIV    = 99,
  parameter int REPEAT_MIN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_ADDR-1:0] A,
  input  logic [N_ADDR-1:0] A_float,
  input  logic [N_DATA-1:0] D,
  input  logic              te,
  output logic              cod_o,
  output logic              sync,
  output logic              busy,
  output logic              word_done
);

`ifdef CODIFICADOR_PARITY_EN
  localparam int N_PAR = 1;
`else
  localparam int N_PAR = 0;
`endif
  localparam int N_BITS = N_ADDR + N_DATA + N_PAR;
  localparam int IW     = $clog2(N_ADDR + N_DATA + 1);
  localparam int RW     = $clog2(REPEAT_MIN + 1);

  logic          w_tick;
  state_t        r_state, w_state_nxt;
  logic [6:0]    r_seg;
  logic [IW-1:0] r_bit_idx;
  logic [RW-1:0] r_rep;
  logic          r_sync, r_word_done;
  trit_t         r_frame     [N_BITS];
  trit_t         w_frame_nxt [N_BITS];
  logic          w_load, w_enter_sync, w_word_end;
  logic          w_bit_end, w_last_bit, w_sync_end;
  trit_t         w_cur;
  logic          w_cod;

  osc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Frame contents as they would be latched right now.
  always_comb begin
    for (int i = 0; i < N_ADDR; i++) begin
      w_frame_nxt[i] = A_float[i] ? TRIT_F : (A[i] ? TRIT_1 : TRIT_0);
    end
    for (int i = 0; i < N_DATA; i++) begin
      w_frame_nxt[N_ADDR+i] = D[i] ? TRIT_1 : TRIT_0;
    end
`ifdef CODIFICADOR_PARITY_EN
    w_frame_nxt[N_ADDR+N_DATA] = (^D) ? TRIT_1 : TRIT_0;
`endif
  end

  assign w_bit_end  = (r_seg == 7'(BIT_TICKS - 1));
  assign w_sync_end = (r_seg == 7'(SYNC_TICKS - 1));
  assign w_last_bit = (r_bit_idx == IW'(N_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_enter_sync = 1'b0;
    w_word_end   = 1'b0;
    case (r_state)
      IDLE: if (w_tick && te) begin
        w_state_nxt = BITS;
        w_load      = 1'b1;
      end
      BITS: if (w_tick && w_bit_end && w_last_bit) begin
        w_state_nxt  = SYNC;
        w_enter_sync = 1'b1;
      end
      SYNC: if (w_tick && w_sync_end) begin
        w_word_end = 1'b1;
        // Pending minimum repeats win over te; te only extends the burst.
        if (r_rep != '0 || te) begin
          w_state_nxt = BITS;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg       <= '0;
      r_bit_idx   <= '0;
      r_rep       <= '0;
      r_sync      <= 1'b0;
      r_word_done <= 1'b0;
      for (int i = 0; i < N_BITS; i++) r_frame[i] <= TRIT_0;
    end else begin
      r_sync      <= w_enter_sync;
      r_word_done <= w_word_end;
      if (w_load) r_frame <= w_frame_nxt;

      if (w_load && r_state == IDLE)     r_rep <= RW'(REPEAT_MIN - 1);
      else if (w_word_end && r_rep != '0) r_rep <= r_rep - 1'b1;

      if (w_load || w_enter_sync || w_word_end)     r_seg <= '0;
      else if (w_tick && r_state == BITS && w_bit_end) r_seg <= '0;
      else if (w_tick && r_state != IDLE)            r_seg <= r_seg + 1'b1;

      if (w_load || w_word_end) r_bit_idx <= '0;
      else if (w_tick && r_state == BITS && w_bit_end && !w_last_bit)
        r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  // Waveform decode: bit segments split into two 16-tick halves (r_seg[4] selects the half).
  assign w_cur = r_frame[r_bit_idx];

  always_comb begin
    w_cod = 1'b0;
    case (r_state)
      BITS:    w_cod = (r_seg[3:0] < half_high_ticks(w_cur, r_seg[4]));
      SYNC:    w_cod = (r_seg < 7'(SHORT));
      default: w_cod = 1'b0;
    endcase
  end

  assign cod_o     = w_cod;
  assign busy      = (r_state != IDLE);
  assign sync      = r_sync;
  assign word_done = r_word_done;

endmodule

// File: tb/tb_codificador_trit_param.sv
module tb_codificador_trit_param;

  localparam int N_ADDR     = 8;
  localparam int N_DATA     = 4;
  localparam int CLK_DIV    = 4;
  localparam int REPEAT_MIN = 4;
`ifdef CODIFICADOR_PARITY_EN
  localparam int N_PAR = 1;
`else
  localparam int N_PAR = 0;
`endif
  localparam int NB         = N_ADDR + N_DATA + N_PAR;
  localparam int WORD_TICKS = NB * 32 + 128;
  localparam int WORD_CLK   = WORD_TICKS * CLK_DIV;
  localparam int SYNC_CLK   = NB * 32 * CLK_DIV;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N_ADDR-1:0] A = '0;
  logic [N_ADDR-1:0] A_float = '0;
  logic [N_DATA-1:0] D = '0;
  logic              te = 1'b0;
  logic              cod_o, sync, busy, word_done;

  codificador_trit_param #(
    .N_ADDR(N_ADDR), .N_DATA(N_DATA), .CLK_DIV(CLK_DIV), .REPEAT_MIN(REPEAT_MIN)
  ) dut (
    .clk(clk), .reset(reset), .A(A), .A_float(A_float), .D(D), .te(te),
    .cod_o(cod_o), .sync(sync), .busy(busy), .word_done(word_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference waveform of one word, one entry per osc tick.
  bit exp_q[$];

  task automatic push_lvl(input bit lv, input int n);
    repeat (n) exp_q.push_back(lv);
  endtask

  // t: 0='0', 1='1', 2='F'
  task automatic push_trit(input int t);
    int h1, h2;
    h1 = (t == 1) ? 12 : 4;
    h2 = (t == 0) ? 4 : 12;
    push_lvl(1'b1, h1); push_lvl(1'b0, 16 - h1);
    push_lvl(1'b1, h2); push_lvl(1'b0, 16 - h2);
  endtask

  task automatic build_exp(input logic [N_ADDR-1:0] a, input logic [N_ADDR-1:0] af,
                           input logic [N_DATA-1:0] d);
    exp_q.delete();
    for (int i = 0; i < N_ADDR; i++) push_trit(af[i] ? 2 : int'(a[i]));
    for (int i = 0; i < N_DATA; i++) push_trit(int'(d[i]));
    if (N_PAR == 1) begin
      int ones = 0;
      for (int i = 0; i < N_DATA; i++) ones += int'(d[i]);
      push_trit(ones % 2);
    end
    push_lvl(1'b1, 4);
    push_lvl(1'b0, 124);
  endtask

  typedef struct {
    logic [N_ADDR-1:0] a;
    logic [N_ADDR-1:0] af;
    logic [N_DATA-1:0] d;
    int                te_words;   // 0: te only until start; else held into word te_words-1
    int                chg_word;   // word in which D changes mid-word, -1 none
    logic [N_DATA-1:0] d_new;
    int                exp_words;
    int                exp_h1;     // clk high in first half of bit 0
    int                exp_h2;     // clk high in second half of bit 0
  } burst_t;

  task automatic run_burst(input burst_t b, input string tag);
    int w;
    A = b.a; A_float = b.af; D = b.d; te = 1'b1;
    w = 0;
    while (busy !== 1'b1 && w < 3 * CLK_DIV) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_start"}, busy, 1);
    if (busy !== 1'b1) begin
      te = 1'b0;
      return;
    end
    if (b.te_words == 0) te = 1'b0;
    for (int k = 0; k < b.exp_words; k++) begin
      int bad, sync_pos, sync_cnt, wd_extra, busy_low, h1, h2;
      bad = -1; sync_pos = -1; sync_cnt = 0; wd_extra = 0; busy_low = 0; h1 = 0; h2 = 0;
      build_exp(A, A_float, D);
      for (int c = 0; c < WORD_CLK; c++) begin
        if (c > 0) @(negedge clk);
        if (c == 0 && k > 0) check($sformatf("%s_w%0d_done", tag, k - 1), word_done, 1);
        if (cod_o !== exp_q[c / CLK_DIV] && bad < 0) bad = c;
        if (sync === 1'b1) begin sync_cnt++; sync_pos = c; end
        if (c > 0 && word_done !== 1'b0) wd_extra++;
        if (busy !== 1'b1) busy_low++;
        if (c < 64 && cod_o === 1'b1) h1++;
        if (c >= 64 && c < 128 && cod_o === 1'b1) h2++;
        if (k == b.chg_word && c == WORD_CLK / 2) D = b.d_new;
        if (b.te_words > 0 && k == b.te_words - 1 && c == WORD_CLK / 2) te = 1'b0;
      end
      check($sformatf("%s_w%0d_wave_first_bad_clk", tag, k), bad, -1);
      check($sformatf("%s_w%0d_sync_cnt", tag, k), sync_cnt, 1);
      check($sformatf("%s_w%0d_sync_pos", tag, k), sync_pos, SYNC_CLK);
      check($sformatf("%s_w%0d_done_midword", tag, k), wd_extra, 0);
      check($sformatf("%s_w%0d_busy_low", tag, k), busy_low, 0);
      if (k == 0) begin
        check({tag, "_b0_high1"}, h1, b.exp_h1);
        check({tag, "_b0_high2"}, h2, b.exp_h2);
      end
      @(negedge clk);
    end
    check({tag, "_end_done"}, word_done, 1);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_cod"}, cod_o, 0);
    te = 1'b0;
    repeat (2 * CLK_DIV + 4) @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, word_done, 0);
  endtask

  burst_t tab[6];
  int     n_tab;

  initial begin
    #1_500_000;
    $display("FAIL watchdog time_limit actual=expired expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{a:8'h05, af:8'h00, d:4'hA, te_words:0, chg_word:-1, d_new:4'h0,
               exp_words:4, exp_h1:48, exp_h2:48};
    tab[1] = '{a:8'h05, af:8'h01, d:4'hA, te_words:0, chg_word:0, d_new:4'h3,
               exp_words:4, exp_h1:16, exp_h2:48};
    tab[2] = '{a:8'h5A, af:8'h30, d:4'h5, te_words:6, chg_word:-1, d_new:4'h0,
               exp_words:6, exp_h1:16, exp_h2:16};
    n_tab = 3;
`ifdef CODIFICADOR_PARITY_EN
    tab[3] = '{a:8'h00, af:8'h00, d:4'hB, te_words:0, chg_word:-1, d_new:4'h0,
               exp_words:4, exp_h1:16, exp_h2:16};
    n_tab = 4;
`endif
    for (int r = 0; r < 2; r++) begin
      burst_t b;
      int t0, f0;
      b.a = N_ADDR'($urandom);
      b.af = N_ADDR'($urandom);
      b.d = N_DATA'($urandom);
      b.te_words = int'($urandom_range(0, 5));
      b.chg_word = -1;
      b.d_new = '0;
      b.exp_words = (b.te_words > REPEAT_MIN) ? b.te_words : REPEAT_MIN;
      t0 = b.af[0] ? 2 : int'(b.a[0]);
      f0 = (t0 == 1) ? 12 : 4;
      b.exp_h1 = f0 * CLK_DIV;
      b.exp_h2 = ((t0 == 0) ? 4 : 12) * CLK_DIV;
      tab[n_tab] = b;
      n_tab++;
    end

    // Reset state, while reset is held.
    #2;
    check("rst_cod", cod_o, 0);
    check("rst_sync", sync, 0);
    check("rst_busy", busy, 0);
    check("rst_done", word_done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CLK_DIV) @(negedge clk);
    check("idle_no_te_busy", busy, 0);

    for (int i = 0; i < n_tab; i++) run_burst(tab[i], $sformatf("burst%0d", i));

    // Asynchronous reset in the middle of a word.
    begin
      int w;
      A = 8'h01; A_float = '0; D = 4'h0; te = 1'b1;
      w = 0;
      while (busy !== 1'b1 && w < 3 * CLK_DIV) begin
        @(negedge clk);
        w++;
      end
      te = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst_pre_cod", cod_o, 1);
      check("midrst_pre_busy", busy, 1);
      #1 reset = 1'b1;
      #1;
      check("midrst_cod", cod_o, 0);
      check("midrst_busy", busy, 0);
      check("midrst_sync", sync, 0);
      check("midrst_done", word_done, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3 * CLK_DIV) @(negedge clk);
      check("midrst_after_busy", busy, 0);
      check("midrst_after_done", word_done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
